nos_dac_scheduler: RTL and testbench

//  Frame scheduler in front of nos_dac_half. Buffers stereo samples from the I2S receiver in a

---
 rtl/nos_dac_scheduler.sv | 173 +++++++++++++++++
 tb/tb_nos_dac_scheduler.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/nos_dac_scheduler.sv
// Frame scheduler for nos_dac_half: sample FIFO, per-period start pulse, bit-depth latch, underrun flag.
// Optional macro NOS_SCHED_HOLD_LAST_EN: repeat the last sample on underrun instead of muting.
package nos_dac_pkg;
  typedef enum logic [1:0] {
    NOS16 = 2'd0,
    NOS24 = 2'd1,
    NOS32 = 2'd2
  } nos_bitnum_t;
endpackage

module nos_dac_scheduler
  import nos_dac_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PRIME_LVL  = 2,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned MIN_PERIOD = 66,
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                enable,
  input  logic [DIV_W-1:0]    period,
  input  nos_bitnum_t         nos_bitnum_i,
  output logic                start,
  output logic [SAMPLE_W-1:0] data_out,
  output nos_bitnum_t         nos_bitnum_o,
  output logic                underrun,
  input  logic                underrun_clr,
  output logic [LVL_W-1:0]    fifo_level
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [SAMPLE_W-1:0] mem_q [FIFO_DEPTH];
  logic [SAMPLE_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [DIV_W-1:0]    period_eff;
  logic                start_q, start_d;
  logic                underrun_q, underrun_d;
  logic [SAMPLE_W-1:0] data_q, data_d;
  nos_bitnum_t         bitnum_q, bitnum_d;
  logic                push, pop, flush, tick;

  assign s_ready      = (level_q < LVL_W'(FIFO_DEPTH));
  assign period_eff   = (period < DIV_W'(MIN_PERIOD)) ? DIV_W'(MIN_PERIOD) : period;
  assign push         = s_valid && s_ready;
  assign pop          = tick && (level_q != '0);

  assign start        = start_q;
  assign data_out     = data_q;
  assign nos_bitnum_o = bitnum_q;
  assign underrun     = underrun_q;
  assign fifo_level   = level_q;

  // Frame FSM: priming, per-period tick, underrun handling
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    start_d    = 1'b0;
    data_d     = data_q;
    bitnum_d   = bitnum_q;
    underrun_d = underrun_q;
    tick       = 1'b0;
    flush      = 1'b0;

    if (underrun_clr) underrun_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) state_d = PRIME;
      end
      PRIME: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (level_q >= LVL_W'(PRIME_LVL)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
          flush   = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          tick     = 1'b1;
          start_d  = 1'b1;
          cnt_d    = period_eff - DIV_W'(1);
          bitnum_d = nos_bitnum_i;
          if (level_q != '0) begin
            data_d = mem_q[rd_ptr_q];
          end else begin
            underrun_d = 1'b1;
`ifdef NOS_SCHED_HOLD_LAST_EN
            data_d = data_q;
`else
            data_d = '0;
`endif
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sample FIFO; a flush on run-stop drops everything including a same-cycle push
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = s_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      cnt_q      <= '0;
      start_q    <= 1'b0;
      underrun_q <= 1'b0;
      data_q     <= '0;
      bitnum_q   <= NOS16;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      start_q    <= start_d;
      underrun_q <= underrun_d;
      data_q     <= data_d;
      bitnum_q   <= bitnum_d;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_nos_dac_scheduler.sv
// Randomized bench for nos_dac_scheduler against a timestamp-based reference model.
module tb_nos_dac_scheduler;
  import nos_dac_pkg::*;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned PRIME_LVL  = 2;
  localparam int unsigned MIN_PERIOD = 66;
  localparam int unsigned N_CYC      = 8000;

  logic        clk;
  logic        reset;
  logic [63:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        enable;
  logic [15:0] period;
  nos_bitnum_t nos_bitnum_i;
  logic        start;
  logic [63:0] data_out;
  nos_bitnum_t nos_bitnum_o;
  logic        underrun;
  logic        underrun_clr;
  logic [2:0]  fifo_level;

  nos_dac_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .enable       (enable),
    .period       (period),
    .nos_bitnum_i (nos_bitnum_i),
    .start        (start),
    .data_out     (data_out),
    .nos_bitnum_o (nos_bitnum_o),
    .underrun     (underrun),
    .underrun_clr (underrun_clr),
    .fifo_level   (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: FIFO as a queue, frame timing as absolute cycle stamps
  logic [63:0] q[$];
  bit          m_armed, m_run, m_start, m_under;
  logic [63:0] m_data;
  nos_bitnum_t m_bn;
  int          cyc, next_start;

  task automatic model_reset();
    q.delete();
    m_armed = 0; m_run = 0; m_start = 0; m_under = 0;
    m_data = '0; m_bn = NOS16; next_start = 0;
  endtask

  task automatic model_step();
    bit pushed, flushed, under_set;
    int p;
    pushed    = s_valid && (q.size() < FIFO_DEPTH);
    flushed   = 0;
    under_set = 0;
    m_start   = 0;
    if (m_run) begin
      if (!enable) begin
        m_run = 0; m_armed = 0; flushed = 1;
        q.delete();
      end else if (cyc == next_start) begin
        p = (int'(period) < MIN_PERIOD) ? MIN_PERIOD : int'(period);
        m_start    = 1;
        m_bn       = nos_bitnum_i;
        next_start = cyc + p;
        if (q.size() > 0) begin
          m_data = q.pop_front();
        end else begin
          under_set = 1;
`ifndef NOS_SCHED_HOLD_LAST_EN
          m_data = '0;
`endif
        end
      end
    end else if (m_armed) begin
      if (!enable) m_armed = 0;
      else if (q.size() >= PRIME_LVL) begin
        m_run = 1; next_start = cyc + 1;
      end
    end else if (enable) begin
      m_armed = 1;
    end
    if (pushed && !flushed) q.push_back(s_data);
    if (underrun_clr) m_under = 0;
    if (under_set) m_under = 1;
    cyc++;
  endtask

  task automatic check_outputs();
    chk("start",      64'(start),        64'(m_start));
    chk("data_out",   data_out,          m_data);
    chk("bitnum_o",   64'(nos_bitnum_o), 64'(m_bn));
    chk("underrun",   64'(underrun),     64'(m_under));
    chk("fifo_level", 64'(fifo_level),   64'(q.size()));
    chk("s_ready",    64'(s_ready),      64'(q.size() < FIFO_DEPTH));
  endtask

  int unsigned pcts[5]    = '{60, 0, 95, 20, 100};
  int unsigned periods[8] = '{10, 50, 65, 66, 67, 80, 100, 130};
  int unsigned push_pct;
  int          n_starts = 0;

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_data = '0; enable = 1'b0;
    period = 16'd100; nos_bitnum_i = NOS16; underrun_clr = 1'b0;
    cyc = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    reset = 1'b0;

    for (int k = 0; k < N_CYC; k++) begin
      if (k == 3000 || k == 6100) begin
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        reset = 1'b0;
      end
      push_pct = pcts[(k / 600) % 5];
      s_valid  = ($urandom_range(0, 99) < push_pct);
      s_data   = {$urandom, $urandom};
      if (k == 0) enable = 1'b1;
      else if (enable && $urandom_range(0, 399) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 9) == 0) enable = 1'b1;
      if ($urandom_range(0, 149) == 0) period = 16'(periods[$urandom_range(0, 7)]);
      if ($urandom_range(0, 29) == 0) nos_bitnum_i = nos_bitnum_t'(2'($urandom_range(0, 2)));
      underrun_clr = ($urandom_range(0, 24) == 0);
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_outputs();
      if (m_start) n_starts++;
    end

    chk("starts_seen", 64'(n_starts > 20), 64'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
